// File: rtl/br_credit_sender_rr_arb.sv
// rtl/br_credit_sender_rr_arb.sv - round-robin arbiter feeding a credit-based push interface
//
// Lets NumRequesters ready/valid producers share one credit-flow-controlled
// push interface. Owns the sender-side credit counter. Grants at most one
// requester per cycle, and only while a usable credit exists. Each accepted
// beat is re-issued one cycle later on a registered pop interface, tagged with
// the index of the requester that produced it.
//
// Ports:
//   clk               clock
//   rst               asynchronous active-low reset
//   push_valid[N]     per-requester valid
//   push_data[N*W]    per-requester data, requester i in bits [i*W +: W]
//   push_ready[N]     one-hot-or-zero grant, combinational
//   pop_credit_stall  receiver must not return credit while high
//   pop_credit        one credit returned this cycle
//   pop_valid         registered beat valid (no backpressure)
//   pop_data          registered beat data
//   pop_id            requester index of the registered beat
//   credit_initial    credit count loaded when leaving init
//   credit_withhold   credits reserved and not usable by requesters
//   credit_count      current credit count
//   credit_available  credit_count > credit_withhold while running
module br_credit_sender_rr_arb #(
  parameter int NumRequesters = 4,
  parameter int Width = 8,
  parameter int MaxCredit = 8,
  localparam int CountWidth = $clog2(MaxCredit + 1),
  localparam int IdWidth = $clog2(NumRequesters)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumRequesters-1:0]       push_valid,
  input  logic [NumRequesters*Width-1:0] push_data,
  output logic [NumRequesters-1:0]       push_ready,
  output logic                           pop_credit_stall,
  input  logic                           pop_credit,
  output logic                           pop_valid,
  output logic [Width-1:0]               pop_data,
  output logic [IdWidth-1:0]             pop_id,
  input  logic [CountWidth-1:0]          credit_initial,
  input  logic [CountWidth-1:0]          credit_withhold,
  output logic [CountWidth-1:0]          credit_count,
  output logic                           credit_available
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t               state;
  logic [IdWidth-1:0]   ptr;
  logic                 grant_valid;
  logic [IdWidth-1:0]   grant_id;
  logic [IdWidth-1:0]   ptr_next;
  logic                 accept;
  logic [CountWidth:0]  count_sum;
  logic [CountWidth-1:0] count_next;

  assign credit_available = (state == ST_RUN) && (credit_count > credit_withhold);

  // Search from the priority pointer upward with wrap-around; the first valid
  // requester found wins. Grant is only exposed while a credit is usable.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NumRequesters) idx = idx - NumRequesters;
      if (!grant_valid && push_valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IdWidth'(idx);
      end
    end
  end

  always_comb begin
    push_ready = '0;
    if (credit_available && grant_valid) push_ready[grant_id] = 1'b1;
  end

  assign accept   = |(push_valid & push_ready);
  assign ptr_next = (grant_id == IdWidth'(NumRequesters - 1)) ? '0 : grant_id + 1'b1;

  // One extra bit so a return on top of a full counter is visible and can be
  // clamped instead of wrapping.
  assign count_sum = {1'b0, credit_count}
                   + {{CountWidth{1'b0}}, pop_credit}
                   - {{CountWidth{1'b0}}, accept};
  assign count_next = (count_sum > (CountWidth + 1)'(MaxCredit)) ? CountWidth'(MaxCredit)
                                                                 : count_sum[CountWidth-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_INIT;
      credit_count     <= '0;
      ptr              <= '0;
      pop_valid        <= 1'b0;
      pop_data         <= '0;
      pop_id           <= '0;
      pop_credit_stall <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          state            <= ST_RUN;
          credit_count     <= credit_initial;
          pop_credit_stall <= 1'b0;
        end
        ST_RUN: begin
          credit_count <= count_next;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
      pop_valid <= accept;
      if (accept) begin
        ptr      <= ptr_next;
        pop_data <= push_data[int'(grant_id)*Width +: Width];
        pop_id   <= grant_id;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      // Credit returned while stalled is dropped by the counter.
      if (state != ST_RUN) assert (!pop_credit);
      // Receiver returned more credit than was ever issued.
      if (state == ST_RUN) assert (count_sum <= (CountWidth + 1)'(MaxCredit));
      if (state == ST_LOAD) assert (credit_initial <= CountWidth'(MaxCredit));
      assert ($onehot0(push_ready));
    end
  end
`endif

endmodule

// File: tb/tb_br_credit_sender_rr_arb.sv
// tb/tb_br_credit_sender_rr_arb.sv - self-checking bench for br_credit_sender_rr_arb
module tb_br_credit_sender_rr_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MC = 8;
  localparam int CW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  push_valid;
  logic [N*W-1:0] push_data;
  logic [N-1:0]  push_ready;
  logic          pop_credit_stall;
  logic          pop_credit;
  logic          pop_valid;
  logic [W-1:0]  pop_data;
  logic [IW-1:0] pop_id;
  logic [CW-1:0] credit_initial;
  logic [CW-1:0] credit_withhold;
  logic [CW-1:0] credit_count;
  logic          credit_available;

  always #5 clk = ~clk;

  br_credit_sender_rr_arb #(.NumRequesters(N), .Width(W), .MaxCredit(MC)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_credit_stall(pop_credit_stall), .pop_credit(pop_credit),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_id(pop_id),
    .credit_initial(credit_initial), .credit_withhold(credit_withhold),
    .credit_count(credit_count), .credit_available(credit_available)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Log of beats seen on the pop side, consumed by the directed checks.
  int log_id[$];
  int log_data[$];
  int log_cyc[$];
  int tb_cyc = 0;
  always @(posedge clk) tb_cyc++;

  // Reference model: cycles since reset release, credit count, priority pointer,
  // and the beat expected on the pop side in the current cycle.
  bit chk_en = 0;
  int m_cyc, m_count, m_ptr, m_pid, m_pd;
  bit m_pv;

  always @(negedge clk) begin
    bit run, avail;
    int g, k;
    logic [N-1:0] exp_ready;
    if (chk_en) begin
      if (!rst) begin
        m_cyc = 0; m_count = 0; m_ptr = 0; m_pv = 0; m_pd = 0; m_pid = 0;
        check("rst_pop_valid", pop_valid, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_pop_id", pop_id, 0);
        check("rst_stall", pop_credit_stall, 1);
        check("rst_push_ready", push_ready, 0);
        check("rst_count", credit_count, 0);
        check("rst_avail", credit_available, 0);
      end else begin
        run   = (m_cyc >= 2);
        avail = run && (m_count > int'(credit_withhold));
        g = -1;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (g < 0 && push_valid[k]) g = k;
        end
        exp_ready = (avail && g >= 0) ? N'(1 << g) : '0;
        check("push_ready", push_ready, exp_ready);
        check("credit_count", credit_count, m_count);
        check("credit_available", credit_available, avail);
        check("pop_credit_stall", pop_credit_stall, !run);
        check("pop_valid", pop_valid, m_pv);
        if (m_pv) begin
          check("pop_data", pop_data, m_pd);
          check("pop_id", pop_id, m_pid);
        end
        if (pop_valid === 1'b1) begin
          log_id.push_back(int'(pop_id));
          log_data.push_back(int'(pop_data));
          log_cyc.push_back(tb_cyc);
        end
        if (m_cyc == 1) m_count = int'(credit_initial);
        else if (run) begin
          m_count = m_count + int'(pop_credit) - ((exp_ready != 0) ? 1 : 0);
          if (m_count > MC) m_count = MC;
        end
        m_pv = (exp_ready != 0);
        if (m_pv) begin
          m_pd  = int'(push_data[g*W +: W]);
          m_pid = g;
          m_ptr = (g + 1) % N;
        end
        if (m_cyc < 2) m_cyc++;
      end
    end
  end

  int outstanding = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_ret();
    cyc();
    pop_credit = pop_valid;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) push_data[i*W +: W] = W'($urandom_range(0, 255));
  endtask

  task automatic clear_log();
    log_id.delete(); log_data.delete(); log_cyc.delete();
  endtask

  // Leaves the bench just after the reset-release edge, still in INIT.
  task automatic do_reset(input int init);
    cyc();
    rst = 1'b0;
    push_valid = '0; pop_credit = 1'b0; credit_withhold = '0;
    credit_initial = CW'(init);
    outstanding = 0;
    cyc();
    cyc();
    clear_log();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; push_valid = '0; push_data = '0; pop_credit = 1'b0;
    credit_initial = '0; credit_withhold = '0;
    #3 rst = 1'b0;
    chk_en = 1;

    // Init sequence
    do_reset(5);
    #2;
    check("init_stall_c0", pop_credit_stall, 1);
    cyc();
    check("init_stall_load", pop_credit_stall, 1);
    check("init_count_load", credit_count, 0);
    cyc();
    check("init_stall_run", pop_credit_stall, 0);
    check("init_count_run", credit_count, 5);
    repeat (4) cyc();
    check("init_no_pop", log_id.size(), 0);

    // Round-robin fairness with one credit returned per beat
    do_reset(8);
    push_valid = 4'hF;
    rand_data();
    repeat (2) cyc_ret();
    for (int i = 0; i < 12; i++) begin
      cyc_ret();
      rand_data();
      if (i == 6) check("rr_count_steady", credit_count, 7);
    end
    push_valid = '0;
    repeat (3) cyc_ret();
    pop_credit = 1'b0;
    check("rr_count_final", credit_count, 8);
    check("rr_beats", log_id.size() >= 8, 1);
    if (log_id.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check("rr_id", log_id[i], i % 4);
        check("rr_back_to_back", log_cyc[i], log_cyc[0] + i);
      end
    end

    // Credit exhaustion and single-credit refill
    do_reset(3);
    push_valid = 4'b0100;
    rand_data();
    push_data[2*W +: W] = 8'hA5;
    repeat (10) cyc();
    check("exh_beats", log_id.size(), 3);
    for (int i = 0; i < log_id.size(); i++) begin
      check("exh_id", log_id[i], 2);
      check("exh_data", log_data[i], 8'hA5);
    end
    check("exh_ready", push_ready, 0);
    check("exh_count", credit_count, 0);
    pop_credit = 1'b1;
    cyc();
    pop_credit = 1'b0;
    check("exh_refill_ready", push_ready, 4'b0100);
    check("exh_refill_count", credit_count, 1);
    repeat (5) cyc();
    check("exh_refill_beats", log_id.size(), 4);

    // Withhold
    do_reset(4);
    credit_withhold = 4'd2;
    push_valid = 4'b0011;
    rand_data();
    repeat (10) cyc();
    check("wh_beats", log_id.size(), 2);
    if (log_id.size() == 2) begin
      check("wh_id0", log_id[0], 0);
      check("wh_id1", log_id[1], 1);
    end
    check("wh_count", credit_count, 2);
    check("wh_ready", push_ready, 0);
    credit_withhold = '0;
    repeat (6) cyc();
    check("wh_beats2", log_id.size(), 4);
    if (log_id.size() == 4) begin
      check("wh_id2", log_id[2], 0);
      check("wh_id3", log_id[3], 1);
    end
    check("wh_count2", credit_count, 0);

    // Simultaneous return and accept
    do_reset(1);
    push_valid = 4'b0001;
    rand_data();
    cyc();
    cyc();
    check("sim_ready0", push_ready, 4'b0001);
    check("sim_count0", credit_count, 1);
    pop_credit = 1'b1;
    cyc();
    pop_credit = 1'b0;
    check("sim_count1", credit_count, 1);
    check("sim_ready1", push_ready, 4'b0001);

    // Random traffic with an asynchronous reset in the middle
    do_reset($urandom_range(1, MC));
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (i == 200) begin
        rst = 1'b0;
        #1;
        check("mid_rst_pop_valid", pop_valid, 0);
        check("mid_rst_stall", pop_credit_stall, 1);
        check("mid_rst_count", credit_count, 0);
        check("mid_rst_ready", push_ready, 0);
        check("mid_rst_avail", credit_available, 0);
        pop_credit = 1'b0;
        credit_withhold = '0;
        credit_initial = CW'(MC);
        push_valid = 4'hF;
        outstanding = 0;
        cyc();
        clear_log();
        rst = 1'b1;
        cyc();
        cyc();
        check("mid_rst_first_grant", push_ready, 4'b0001);
      end else begin
        if (pop_valid) outstanding++;
        push_valid = N'($urandom);
        rand_data();
        credit_withhold = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 3)) : '0;
        pop_credit = 1'b0;
        if (outstanding > 0 && $urandom_range(0, 1) == 1) begin
          pop_credit = 1'b1;
          outstanding--;
        end
      end
    end
    cyc();
    pop_credit = 1'b0;
    check("rand_some_beats", log_id.size() > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
